// File: rtl/pool_feature_reader_if.sv
// AXI4 read (AR/R) channels plus the element stream into the pooling feature FIFO.
// master = the reader, slave = memory / interconnect / FIFO side.
interface pool_feature_reader_if #(
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_AD = 32,
  parameter int DATA_WIDTH   = 32
) ();
  logic [AXI_WIDTH_ID-1:0] ARID;
  logic [AXI_WIDTH_AD-1:0] ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [AXI_WIDTH_ID-1:0] RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  logic [DATA_WIDTH-1:0]   OUT_DATA;
  logic                    OUT_VALID;
  logic                    OUT_READY;
  logic                    OUT_EOR;
  logic                    OUT_EOF;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
           OUT_DATA, OUT_VALID, OUT_EOR, OUT_EOF,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID, OUT_READY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
           OUT_DATA, OUT_VALID, OUT_EOR, OUT_EOF,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID, OUT_READY
  );
endinterface

// File: rtl/pool_feature_reader.sv
// Burst-reads a row-major feature map over AXI4 and streams elements with row/frame markers.
// R->OUT is a 0-cycle pass-through; OUT_READY backpressure stalls RREADY directly.
module pool_feature_reader #(
  parameter int AXI_WIDTH_ID = 4,
  parameter int AXI_WIDTH_AD = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_MAX    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    GO,
  input  logic [AXI_WIDTH_AD-1:0] BASE,
  input  logic [11:0]             WIDTH,
  input  logic [11:0]             HEIGHT,
  input  logic [15:0]             STRIDE,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR,
  pool_feature_reader_if.master   bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [AXI_WIDTH_AD-1:0] row_addr_q;
  logic [11:0]             width_q, height_q, col_q, row_q;
  logic [15:0]             stride_q;
  logic [7:0]              len_q, beat_q;
  logic                    error_q;

  logic [AXI_WIDTH_AD-1:0] cur_addr;
  logic [12:0]             left_row, left_4k, burst_cap, beats;
  logic [7:0]              arlen;
  logic                    r_fire, last_beat, last_col, last_row;
  logic                    unused_rid;

  assign unused_rid = ^bus.RID;

  assign cur_addr  = row_addr_q + (AXI_WIDTH_AD'(col_q) << SIZE);
  assign left_row  = {1'b0, width_q - col_q};
  assign left_4k   = (13'h1000 - {1'b0, cur_addr[11:0]}) >> SIZE;
  assign burst_cap = 13'(BURST_MAX);

  // Burst length is the tightest of row remainder, BURST_MAX and the 4KB page remainder.
  always_comb begin
    beats = left_row;
    if (burst_cap < beats) beats = burst_cap;
    if (left_4k < beats)   beats = left_4k;
  end

  assign arlen     = 8'(beats - 13'd1);
  assign r_fire    = (state_q == S_DATA) && bus.RVALID && bus.OUT_READY;
  assign last_beat = (beat_q == len_q);
  assign last_col  = (col_q == width_q - 12'd1);
  assign last_row  = (row_q == height_q - 12'd1);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (GO) state_d = (WIDTH == 12'd0 || HEIGHT == 12'd0) ? S_DONE : S_ADDR;
      S_ADDR: if (bus.ARREADY) state_d = S_DATA;
      S_DATA: if (r_fire && last_beat) state_d = (last_col && last_row) ? S_DONE : S_ADDR;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ARID      = '0;
    bus.ARADDR    = '0;
    bus.ARLEN     = '0;
    bus.ARSIZE    = '0;
    bus.ARBURST   = '0;
    bus.ARVALID   = 1'b0;
    bus.RREADY    = 1'b0;
    bus.OUT_DATA  = '0;
    bus.OUT_VALID = 1'b0;
    bus.OUT_EOR   = 1'b0;
    bus.OUT_EOF   = 1'b0;
    BUSY          = 1'b0;
    DONE          = 1'b0;
    case (state_q)
      S_ADDR: begin
        BUSY        = 1'b1;
        bus.ARVALID = 1'b1;
        bus.ARADDR  = cur_addr;
        bus.ARLEN   = arlen;
        bus.ARSIZE  = 3'(SIZE);
        bus.ARBURST = 2'b01;
      end
      S_DATA: begin
        BUSY          = 1'b1;
        bus.RREADY    = bus.OUT_READY;
        bus.OUT_DATA  = bus.RDATA;
        bus.OUT_VALID = bus.RVALID;
        bus.OUT_EOR   = bus.RVALID && last_col;
        bus.OUT_EOF   = bus.RVALID && last_col && last_row;
      end
      S_DONE: DONE = 1'b1;
      default: ;
    endcase
  end

  assign ERROR = error_q;

  // Beats are counted locally; RLAST is only cross-checked, never trusted for sequencing.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      row_addr_q <= '0;
      width_q    <= '0;
      height_q   <= '0;
      stride_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      error_q    <= 1'b0;
    end else begin
      if (state_q == S_IDLE && GO) begin
        row_addr_q <= BASE;
        width_q    <= WIDTH;
        height_q   <= HEIGHT;
        stride_q   <= STRIDE;
        col_q      <= '0;
        row_q      <= '0;
        error_q    <= 1'b0;
      end
      if (state_q == S_ADDR && bus.ARREADY) begin
        len_q  <= arlen;
        beat_q <= '0;
      end
      if (r_fire) begin
        beat_q <= beat_q + 8'd1;
        if (bus.RRESP != 2'b00 || bus.RLAST != last_beat) error_q <= 1'b1;
        if (last_col) begin
          col_q      <= '0;
          row_q      <= row_q + 12'd1;
          row_addr_q <= row_addr_q + AXI_WIDTH_AD'(stride_q);
        end else begin
          col_q <= col_q + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_feature_reader.sv
// Directed bench: a small AXI memory model answers bursts; streams and AR requests are scoreboarded.
module tb_pool_feature_reader;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        GO = 1'b0;
  logic [31:0] BASE = '0;
  logic [11:0] WIDTH = '0;
  logic [11:0] HEIGHT = '0;
  logic [15:0] STRIDE = '0;
  logic        BUSY, DONE, ERROR;

  pool_feature_reader_if #(.AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .DATA_WIDTH(32)) bus ();

  pool_feature_reader #(
    .AXI_WIDTH_ID(4), .AXI_WIDTH_AD(32), .DATA_WIDTH(32), .BURST_MAX(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .GO(GO), .BASE(BASE), .WIDTH(WIDTH),
    .HEIGHT(HEIGHT), .STRIDE(STRIDE), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .bus(bus.master)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // memory model state and observation buffers
  bit          rnd_rdy = 0;
  int          dmax = 0;
  int          inj_slv = -1;
  int          inj_early = -1;
  bit          r_act = 0, ar_f = 0, r_f = 0;
  logic [31:0] r_addr, cap_addr;
  int          r_len, r_beat, r_cnt = 0, ar_cnt = 0, cap_len;

  logic [31:0] got_data[$];
  logic [1:0]  got_flag[$];
  logic [31:0] got_ar_addr[$];
  int          got_ar_len[$];
  logic [31:0] exp_ar_addr[$];
  int          exp_ar_len[$];
  int          done_cnt, rr_err, ov_err, ovl_err, attr_err, arv_cycles;

  function automatic int rdly();
    return (dmax == 0) ? 0 : int'($urandom_range(0, dmax));
  endfunction

  initial begin
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = '0; bus.RRESP = '0;
    bus.RLAST = 0; bus.RID = '0; bus.OUT_READY = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        r_act = 0; ar_f = 0; r_f = 0; ar_cnt = 0; r_cnt = 0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RLAST = 0; bus.OUT_READY = 0;
      end else begin
        if (r_f) begin
          r_beat++;
          if (r_beat > r_len) r_act = 0;
          r_cnt = rdly();
        end else if (r_act && r_cnt > 0) begin
          r_cnt--;
        end
        if (ar_f) begin
          r_act = 1; r_addr = cap_addr; r_len = cap_len; r_beat = 0;
          r_cnt = rdly(); ar_cnt = rdly();
        end
        bus.ARREADY   = (ar_cnt == 0);
        bus.RVALID    = r_act && (r_cnt == 0);
        bus.RDATA     = r_act ? memval(r_addr + 32'(r_beat) * 4) : 32'h0;
        bus.RRESP     = (r_act && r_beat == inj_slv) ? 2'b10 : 2'b00;
        bus.RLAST     = r_act && ((inj_early >= 0) ? (r_beat == inj_early) : (r_beat == r_len));
        bus.OUT_READY = rnd_rdy ? ($urandom_range(0, 99) >= 30) : 1'b1;
      end
      #1;
      ar_f = !ARESET && bus.ARVALID && bus.ARREADY;
      r_f  = !ARESET && bus.RVALID && bus.RREADY;
      if (bus.ARVALID) begin
        arv_cycles++;
        if (!bus.ARREADY && ar_cnt > 0) ar_cnt--;
        if (r_act) ovl_err++;
      end
      if (ar_f) begin
        cap_addr = bus.ARADDR;
        cap_len  = int'(bus.ARLEN);
        got_ar_addr.push_back(bus.ARADDR);
        got_ar_len.push_back(int'(bus.ARLEN));
        if (bus.ARSIZE !== 3'd2 || bus.ARBURST !== 2'b01 || bus.ARID !== 4'd0) attr_err++;
      end
      if (!ARESET && bus.RVALID && bus.RREADY !== bus.OUT_READY) rr_err++;
      if (!ARESET && BUSY && !bus.ARVALID && bus.OUT_VALID !== bus.RVALID) ov_err++;
      if (r_f) begin
        got_data.push_back(bus.OUT_DATA);
        got_flag.push_back({bus.OUT_EOR, bus.OUT_EOF});
        if (!bus.OUT_VALID) ov_err++;
      end
      if (DONE) done_cnt++;
    end
  end

  task automatic clear_obs();
    got_data.delete(); got_flag.delete(); got_ar_addr.delete(); got_ar_len.delete();
    done_cnt = 0; rr_err = 0; ov_err = 0; ovl_err = 0; attr_err = 0; arv_cycles = 0;
  endtask

  task automatic exp_ar(input logic [31:0] a, input int len);
    exp_ar_addr.push_back(a);
    exp_ar_len.push_back(len);
  endtask

  task automatic go_pulse(input logic [31:0] b, input int w, input int h, input int s);
    @(negedge ACLK);
    BASE = b; WIDTH = 12'(w); HEIGHT = 12'(h); STRIDE = 16'(s); GO = 1'b1;
    @(negedge ACLK);
    GO = 1'b0;
    #2;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge ACLK);
    repeat (3) @(negedge ACLK);
    #2;
  endtask

  task automatic run(input logic [31:0] b, input int w, input int h, input int s);
    clear_obs();
    go_pulse(b, w, h, s);
    check_eq("error_clear_on_go", ERROR, 0);
    wait_done(3000);
  endtask

  task automatic check_run(input logic [31:0] b, input int w, input int h, input int s);
    int idx;
    check_eq("done_count", done_cnt, 1);
    check_eq("ar_count", got_ar_addr.size(), exp_ar_addr.size());
    for (int i = 0; i < exp_ar_addr.size() && i < got_ar_addr.size(); i++) begin
      check_eq($sformatf("araddr[%0d]", i), got_ar_addr[i], exp_ar_addr[i]);
      check_eq($sformatf("arlen[%0d]", i), got_ar_len[i], exp_ar_len[i]);
    end
    check_eq("beat_count", got_data.size(), w * h);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        idx = r * w + c;
        if (idx < got_data.size()) begin
          check_eq($sformatf("data[%0d]", idx), got_data[idx],
                   memval(b + 32'(r) * 32'(s) + 32'(c) * 4));
          check_eq($sformatf("eor_eof[%0d]", idx), got_flag[idx],
                   {c == w - 1, (c == w - 1) && (r == h - 1)});
        end
      end
    end
    check_eq("rready_eq_outready", rr_err, 0);
    check_eq("out_valid_track", ov_err, 0);
    check_eq("one_outstanding", ovl_err, 0);
    check_eq("ar_attributes", attr_err, 0);
    exp_ar_addr.delete();
    exp_ar_len.delete();
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bit reached;
    repeat (3) @(negedge ACLK);
    #2;
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_done", DONE, 0);
    check_eq("rst_error", ERROR, 0);
    check_eq("rst_arvalid", bus.ARVALID, 0);
    check_eq("rst_araddr", bus.ARADDR, 0);
    check_eq("rst_rready", bus.RREADY, 0);
    check_eq("rst_out_valid", bus.OUT_VALID, 0);
    check_eq("rst_out_eor", bus.OUT_EOR, 0);
    @(negedge ACLK);
    #2 ARESET = 1'b0;

    // 8x4 map, one burst per row
    for (int r = 0; r < 4; r++) exp_ar(32'h1000 + 32'(r) * 32, 7);
    run(32'h1000, 8, 4, 32);
    check_run(32'h1000, 8, 4, 32);

    // single long row split by BURST_MAX
    exp_ar(32'h0, 15); exp_ar(32'h40, 15); exp_ar(32'h80, 7);
    run(32'h0, 40, 1, 160);
    check_run(32'h0, 40, 1, 160);

    // row crossing a 4KB page
    exp_ar(32'h0FF0, 3); exp_ar(32'h1000, 3);
    run(32'h0FF0, 8, 1, 32);
    check_run(32'h0FF0, 8, 1, 32);

    // 7x7 with random ready / latency
    rnd_rdy = 1; dmax = 5;
    for (int r = 0; r < 7; r++) exp_ar(32'h2000 + 32'(r) * 32'h40, 6);
    run(32'h2000, 7, 7, 32'h40);
    check_run(32'h2000, 7, 7, 32'h40);
    rnd_rdy = 0; dmax = 0;

    // SLVERR on the third beat
    inj_slv = 2;
    exp_ar(32'h300, 3);
    run(32'h300, 4, 1, 16);
    check_run(32'h300, 4, 1, 16);
    check_eq("error_slverr", ERROR, 1);
    inj_slv = -1;

    // RLAST on beat 2 of 4; GO must clear the earlier error first
    inj_early = 1;
    exp_ar(32'h300, 3);
    run(32'h300, 4, 1, 16);
    check_run(32'h300, 4, 1, 16);
    check_eq("error_early_rlast", ERROR, 1);
    inj_early = -1;

    // zero-width frame: no AXI traffic, immediate DONE
    clear_obs();
    go_pulse(32'h500, 0, 3, 16);
    check_eq("w0_done", DONE, 1);
    check_eq("w0_busy", BUSY, 0);
    check_eq("w0_error_cleared", ERROR, 0);
    @(negedge ACLK);
    #2;
    check_eq("w0_done_pulse", DONE, 0);
    repeat (3) @(negedge ACLK);
    check_eq("w0_done_count", done_cnt, 1);
    check_eq("w0_no_arvalid", arv_cycles, 0);

    // second GO while busy is ignored
    clear_obs();
    exp_ar(32'h4000, 7); exp_ar(32'h4020, 7);
    go_pulse(32'h4000, 8, 2, 32);
    check_eq("busy_after_go", BUSY, 1);
    go_pulse(32'h5000, 3, 1, 16);
    wait_done(3000);
    check_run(32'h4000, 8, 2, 32);

    // reset in the middle of a data phase
    clear_obs();
    rnd_rdy = 1; dmax = 2;
    go_pulse(32'h6000, 16, 4, 64);
    reached = 0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(negedge ACLK);
      #2;
      reached = (got_data.size() >= 3) && BUSY && !bus.ARVALID;
    end
    check_eq("rst_mid_reached_data", reached, 1);
    ARESET = 1'b1;
    #1;
    check_eq("rst_mid_arvalid", bus.ARVALID, 0);
    check_eq("rst_mid_rready", bus.RREADY, 0);
    check_eq("rst_mid_out_valid", bus.OUT_VALID, 0);
    check_eq("rst_mid_busy", BUSY, 0);
    repeat (2) @(negedge ACLK);
    #2 ARESET = 1'b0;
    rnd_rdy = 0; dmax = 0;
    exp_ar(32'h7000, 3); exp_ar(32'h7010, 3);
    run(32'h7000, 4, 2, 16);
    check_run(32'h7000, 4, 2, 16);
    check_eq("post_reset_error", ERROR, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
